// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: issues loads/stores on a req/gnt/rvalid bus and fills the MEM/WB register.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of issuing them aligned down.
module mem_stage_lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            ex_mem_valid_i,
  input  logic [31:0]     pc_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      funct3_i,
  input  logic            mem_rd_en_i,
  input  logic            mem_wr_en_i,
  input  logic [4:0]      rd_i,
  input  logic            reg_wr_en_i,
  input  logic [1:0]      src_to_reg_i,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  output logic            lsu_stall_o,
  output logic            wb_valid_o,
  output logic [31:0]     wb_pc_o,
  output logic [XLEN-1:0] wb_alu_o,
  output logic [XLEN-1:0] wb_load_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_reg_wr_en_o,
  output logic [1:0]      wb_src_to_reg_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e          r_state;
  logic            r_wb_valid;
  logic [31:0]     r_wb_pc;
  logic [XLEN-1:0] r_wb_alu;
  logic [XLEN-1:0] r_wb_load;
  logic [4:0]      r_wb_rd;
  logic            r_wb_reg_wr_en;
  logic [1:0]      r_wb_src_to_reg;

  logic            w_mem_op;
  logic            w_trap;
  logic            w_issue;
  logic            w_rsp;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_load_fmt;

  assign w_mem_op = ex_mem_valid_i & (mem_rd_en_i | mem_wr_en_i);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign;

  always_comb begin
    w_misalign = 1'b0;
    case (funct3_i[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = addr_i[0];
      default: w_misalign = (addr_i[1:0] != 2'b00);
    endcase
  end

  assign w_trap     = w_mem_op & w_misalign;
  assign misalign_o = r_misalign;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (lsu_stall_o) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_trap;
    end
  end
`else
  assign w_trap     = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign w_issue     = w_mem_op & ~w_trap;
  assign dbus_req_o  = w_issue & (r_state != StWait);
  assign w_rsp       = (r_state == StWait) & dbus_rvalid_i;
  // Loads always stall through the grant cycle; stores only until granted.
  assign lsu_stall_o = ((r_state == StWait) & ~dbus_rvalid_i) |
                       (dbus_req_o & (~dbus_gnt_i | mem_rd_en_i));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {addr_i[1], 1'b0};
        w_wdata = {2{store_data_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data_i;
      end
    endcase
  end

  assign dbus_we_o    = dbus_req_o & mem_wr_en_i;
  assign dbus_addr_o  = dbus_req_o ? {addr_i[XLEN-1:2], 2'b00} : '0;
  assign dbus_be_o    = dbus_req_o ? w_be : 4'b0000;
  assign dbus_wdata_o = dbus_we_o ? w_wdata : '0;

  assign w_shift = dbus_rdata_i >> {addr_i[1:0], 3'b000};

  always_comb begin
    w_load_fmt = w_shift;
    case (funct3_i)
      3'b000:  w_load_fmt = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load_fmt = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load_fmt = {{(XLEN-8){1'b0}}, w_shift[7:0]};
      3'b101:  w_load_fmt = {{(XLEN-16){1'b0}}, w_shift[15:0]};
      default: w_load_fmt = w_shift;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle, StReq: begin
          if (!w_issue) begin
            r_state <= StIdle;
          end else if (dbus_gnt_i) begin
            r_state <= mem_rd_en_i ? StWait : StIdle;
          end else begin
            r_state <= StReq;
          end
        end
        StWait: begin
          if (dbus_rvalid_i) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Stalled cycles insert a bubble; payload fields keep their last value.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid      <= 1'b0;
      r_wb_pc         <= '0;
      r_wb_alu        <= '0;
      r_wb_load       <= '0;
      r_wb_rd         <= '0;
      r_wb_reg_wr_en  <= 1'b0;
      r_wb_src_to_reg <= '0;
    end else if (lsu_stall_o) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_wr_en  <= 1'b0;
    end else begin
      r_wb_valid      <= ex_mem_valid_i;
      r_wb_pc         <= pc_i;
      r_wb_alu        <= addr_i;
      r_wb_load       <= w_rsp ? w_load_fmt : '0;
      r_wb_rd         <= rd_i;
      r_wb_reg_wr_en  <= ex_mem_valid_i & reg_wr_en_i & ~w_trap;
      r_wb_src_to_reg <= src_to_reg_i;
    end
  end

  assign wb_valid_o      = r_wb_valid;
  assign wb_pc_o         = r_wb_pc;
  assign wb_alu_o        = r_wb_alu;
  assign wb_load_o       = r_wb_load;
  assign wb_rd_o         = r_wb_rd;
  assign wb_reg_wr_en_o  = r_wb_reg_wr_en;
  assign wb_src_to_reg_o = r_wb_src_to_reg;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-access stage of the RV32I pipeline, consuming the EX/MEM pipeline register outputs and producing the MEM/WB register contents. It issues loads and stores on a req/gnt/rvalid data bus, generates byte enables and store-lane replication, aligns and sign/zero-extends load data, and stalls the upstream pipeline while an access is outstanding. One access is in flight at a time.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- CLK  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ex_mem_valid_i  in  1  an instruction is present in EX/MEM.
- pc_i  in  32  instruction PC.
- addr_i  in  XLEN  ALU result, used as the effective address and as the writeback value.
- store_data_i  in  XLEN  rs2 value for stores.
- funct3_i  in  3  access size and sign.
- mem_rd_en_i / mem_wr_en_i  in  1 each  load / store.
- rd_i  in  5; reg_wr_en_i  in  1; src_to_reg_i  in  2  writeback control, passed through.
- dbus_req_o  out  1; dbus_we_o  out  1; dbus_addr_o  out  XLEN (bits [1:0] = 0); dbus_be_o  out  4; dbus_wdata_o  out  XLEN.
- dbus_gnt_i  in  1; dbus_rvalid_i  in  1; dbus_rdata_i  in  XLEN.
- lsu_stall_o  out  1  holds the upstream stages; combinational.
- wb_valid_o, wb_pc_o, wb_alu_o, wb_load_o, wb_rd_o, wb_reg_wr_en_o, wb_src_to_reg_o  out  MEM/WB register fields.
- misalign_o  out  1  registered misalignment flag.

## Operation
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- IDLE with a valid memory instruction: assert dbus_req_o combinationally.
  - gnt with a store: the store completes; no stall.
  - gnt with a load: go to WAIT.
  - No gnt: go to REQ.
- REQ: hold req and all bus outputs stable until gnt; then a store goes to IDLE and a load goes to WAIT.
- WAIT: req is low. On rvalid, capture the formatted data and go to IDLE.
- A non-memory instruction passes straight through to MEM/WB.
- lsu_stall_o = 1 whenever a memory instruction is not completing in the current cycle:
  - IDLE or REQ without gnt;
  - a load in IDLE or REQ, including the gnt cycle;
  - WAIT without rvalid.
- Inputs are held stable by upstream while lsu_stall_o = 1.
- Byte enables:
  - Byte access (funct3[1:0] = 00): be = 4'b0001 << addr[1:0].
  - Half access (01): be = 4'b0011 << (2*addr[1]).
  - Word access, and the load funct3 codes 011/110/111: be = 4'b1111; these loads behave as LW.
- Store data replication: a byte is copied to all 4 lanes, a half to both halves, a word unchanged.
- Load formatting: shift rdata right by 8*addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Misaligned access: a half with addr[0] = 1, or a word with addr[1:0] != 0. Handling is set by the Configuration macro.
- rvalid in IDLE or REQ is ignored.

## Timing
- MEM/WB register updates on every non-stalled cycle.
- While stalled, MEM/WB captures a bubble: wb_valid_o = 0 and wb_reg_wr_en_o = 0.
- Latency, measured as cycles from the instruction entering EX/MEM to wb_valid_o:
  - non-memory op: 1;
  - store with immediate gnt: 1;
  - load with gnt in cycle 0 and rvalid in cycle 1: 2 (one stall cycle).
  - Each extra cycle of gnt or rvalid delay adds one cycle.
- Reset values: all wb_* outputs = 0, misalign_o = 0, dbus_req_o = 0, dbus_we_o = 0, dbus_be_o = 0, dbus_addr_o = 0, dbus_wdata_o = 0, lsu_stall_o = 0, state = IDLE.
- Reset mid-access drops the access. A late rvalid after reset is ignored.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access is not issued (no req) and does not stall.
  - MEM/WB captures it with misalign_o = 1 and wb_reg_wr_en_o forced to 0.
  - misalign_o is valid only alongside wb_valid_o.
- Not defined:
  - The address is aligned down (dbus_addr_o = {addr[31:2], 2'b00}), with be and formatting computed from addr[1:0] as above.
  - misalign_o is tied to 0.

## Test plan
- SB with addr 0x1003, data 0x000000A5, gnt in the same cycle -> be = 1000, wdata = 0xA5A5A5A5, no stall, wb_valid_o = 1 one cycle later.
- LH with addr 0x2002, gnt immediate, rvalid one cycle later with rdata 0x8001_1234 -> stall for 1 cycle, wb_load_o = 0xFFFF8001.
- LBU with addr 0x0001, gnt delayed 3 cycles, rvalid 2 cycles after gnt, rdata 0x0000_FF00 -> req held stable for 3 cycles, stall 5 cycles total, wb_load_o = 0x000000FF, bubbles in between.
- LW with addr 0x0006:
  - with the macro: no req, misalign_o = 1, wb_reg_wr_en_o = 0;
  - without the macro: dbus_addr_o = 0x0004, be = 1111.
- Reset asserted in WAIT, rvalid arriving after release -> FSM is IDLE, outputs stay 0, rvalid is ignored.
- ADD result 0x1234 with no memory op -> wb_alu_o = 0x1234 next cycle, dbus_req_o never asserted.
